// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA pixel-timing generator: scan counters, registered syncs,
// pipeline-aligned delayed syncs and frame-level pulse/counter/irq.
module vga_timing_gen #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int PIPE_DELAY = 2
) (
    input  logic        vga_clk,
    input  logic        reset_n,
    input  logic        irq_ack,
    output logic [9:0]  DrawX,
    output logic [9:0]  DrawY,
    output logic        hs,
    output logic        vs,
    output logic        blank,
    output logic        hs_d,
    output logic        vs_d,
    output logic        blank_d,
    output logic        frame_start,
    output logic [15:0] frame_count,
    output logic        frame_irq
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] L_H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] L_V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] L_H_VIS  = 10'(H_VISIBLE);
    localparam logic [9:0] L_V_VIS  = 10'(V_VISIBLE);
    localparam logic [9:0] L_HS_BEG = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] L_HS_END = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] L_VS_BEG = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] L_VS_END = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [9:0]  r_hc;
    logic [9:0]  r_vc;
    logic        r_hs;
    logic        r_vs;
    logic        r_blank;
    logic        r_frame_start;
    logic [15:0] r_frame_count;
    logic        r_frame_irq;

    logic [9:0]  w_hc_nxt;
    logic [9:0]  w_vc_nxt;
    logic        w_h_end;
    logic        w_wrap;
    logic        w_vbl_start;
    logic        w_hs_nxt;
    logic        w_vs_nxt;
    logic        w_blank_nxt;

    always_comb begin
        w_h_end     = (r_hc == L_H_LAST);
        w_wrap      = w_h_end && (r_vc == L_V_LAST);
        w_vbl_start = w_h_end && (r_vc == L_V_VIS - 10'd1);
        w_hc_nxt    = w_h_end ? 10'd0 : r_hc + 10'd1;
        w_vc_nxt    = r_vc;
        if (w_h_end) begin
            w_vc_nxt = w_wrap ? 10'd0 : r_vc + 10'd1;
        end
        // Decode the next-state counters so the registered syncs line up with them
        w_blank_nxt = (w_hc_nxt < L_H_VIS) && (w_vc_nxt < L_V_VIS);
        w_hs_nxt    = !((w_hc_nxt >= L_HS_BEG) && (w_hc_nxt < L_HS_END));
        w_vs_nxt    = !((w_vc_nxt >= L_VS_BEG) && (w_vc_nxt < L_VS_END));
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hc          <= '0;
            r_vc          <= '0;
            r_hs          <= 1'b1;
            r_vs          <= 1'b1;
            r_blank       <= 1'b1;
            r_frame_start <= 1'b0;
            r_frame_count <= '0;
            r_frame_irq   <= 1'b0;
        end else begin
            r_hc          <= w_hc_nxt;
            r_vc          <= w_vc_nxt;
            r_hs          <= w_hs_nxt;
            r_vs          <= w_vs_nxt;
            r_blank       <= w_blank_nxt;
            r_frame_start <= w_wrap;
            if (w_wrap) begin
                r_frame_count <= r_frame_count + 16'd1;
            end
            // A set on the same edge as an ack takes priority
            if (w_vbl_start) begin
                r_frame_irq <= 1'b1;
            end else if (irq_ack) begin
                r_frame_irq <= 1'b0;
            end
        end
    end

    generate
        if (PIPE_DELAY == 0) begin : g_nodly
            assign hs_d    = r_hs;
            assign vs_d    = r_vs;
            assign blank_d = r_blank;
        end else begin : g_dly
            logic [2:0] r_dly [PIPE_DELAY];

            always_ff @(posedge vga_clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int i = 0; i < PIPE_DELAY; i++) begin
                        r_dly[i] <= 3'b110;
                    end
                end else begin
                    r_dly[0] <= {r_hs, r_vs, r_blank};
                    for (int i = 1; i < PIPE_DELAY; i++) begin
                        r_dly[i] <= r_dly[i-1];
                    end
                end
            end

            assign {hs_d, vs_d, blank_d} = r_dly[PIPE_DELAY-1];
        end
    endgenerate

    assign DrawX       = r_hc;
    assign DrawY       = r_vc;
    assign hs          = r_hs;
    assign vs          = r_vs;
    assign blank       = r_blank;
    assign frame_start = r_frame_start;
    assign frame_count = r_frame_count;
    assign frame_irq   = r_frame_irq;

endmodule
